// File: rtl/btn_led_ctrl.sv
// Three-button LED counter controller: synchronised/debounced buttons drive a
// MANUAL / AUTO_UP / AUTO_DOWN / PAUSE state machine. Optional auto-repeat: BTN_LED_CTRL_REPEAT_EN.

module btn_led_ctrl_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_n_i,
    output logic level_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             deb_r;
    logic [CNT_W-1:0] cnt_r;

    // Two-flop synchroniser on the active-high button, then stability counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            deb_r   <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= ~btn_n_i;
            sync2_r <= sync1_r;
            if (sync2_r != deb_r) begin
                if (cnt_r == CNT_LAST) begin
                    deb_r <= sync2_r;
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign level_o = deb_r;

endmodule

module btn_led_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned TICK_CYCLES     = 12500000
`ifdef BTN_LED_CTRL_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 4 * TICK_CYCLES,
    parameter int unsigned REPEAT_PERIOD   = TICK_CYCLES
`endif
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       btn_up_n_i,
    input  logic       btn_down_n_i,
    input  logic       btn_mode_n_i,
    output logic [3:0] led_n_o,
    output logic [1:0] mode_o
);

    typedef enum logic [1:0] {
        MANUAL    = 2'b00,
        AUTO_UP   = 2'b01,
        AUTO_DOWN = 2'b10,
        PAUSE     = 2'b11
    } state_t;

    localparam int unsigned PRE_W = $clog2(TICK_CYCLES);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

    logic [2:0]       lvl_s;
    logic [2:0]       lvl_prev_r;
    logic [2:0]       ev_s;
    logic             up_step_s;
    logic             dn_step_s;
    logic             rep_up_s;
    logic             rep_dn_s;
    state_t           state_r;
    state_t           state_s;
    logic [3:0]       count_r;
    logic [3:0]       count_s;
    logic [PRE_W-1:0] presc_r;
    logic             auto_s;
    logic             tick_s;

    btn_led_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .btn_n_i(btn_up_n_i), .level_o(lvl_s[0])
    );
    btn_led_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .btn_n_i(btn_down_n_i), .level_o(lvl_s[1])
    );
    btn_led_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .btn_n_i(btn_mode_n_i), .level_o(lvl_s[2])
    );

    // Previous debounced levels for rising-edge (press) detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lvl_prev_r <= 3'b000;
        end else begin
            lvl_prev_r <= lvl_s;
        end
    end

    // Press pulses are high for the cycle right after the debounced level rises.
    assign ev_s = lvl_s & ~lvl_prev_r;

`ifdef BTN_LED_CTRL_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W = $clog2(REP_MAX);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt_r;
    logic             rep_first_r;
    logic             rep_hold_s;
    logic             rep_fire_s;

    assign rep_hold_s = (state_r == MANUAL) && (lvl_s[0] ^ lvl_s[1]);
    assign rep_fire_s = rep_hold_s &&
                        (rep_cnt_r == (rep_first_r ? REP_DELAY_LAST : REP_PERIOD_LAST));
    assign rep_up_s   = rep_fire_s & lvl_s[0];
    assign rep_dn_s   = rep_fire_s & lvl_s[1];

    // Repeat timer: restarts on any press, leaving MANUAL, or a change in held buttons.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rep_cnt_r   <= '0;
            rep_first_r <= 1'b1;
        end else if (!rep_hold_s || (ev_s != 3'b000)) begin
            rep_cnt_r   <= '0;
            rep_first_r <= 1'b1;
        end else if (rep_fire_s) begin
            rep_cnt_r   <= '0;
            rep_first_r <= 1'b0;
        end else begin
            rep_cnt_r   <= rep_cnt_r + 1'b1;
        end
    end
`else
    assign rep_up_s = 1'b0;
    assign rep_dn_s = 1'b0;
`endif

    assign up_step_s = ev_s[0] | rep_up_s;
    assign dn_step_s = ev_s[1] | rep_dn_s;
    assign auto_s    = (state_r == AUTO_UP) || (state_r == AUTO_DOWN);
    assign tick_s    = auto_s && (presc_r == PRE_LAST);

    // Mode state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= MANUAL;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state: each mode press advances one step around the ring.
    always_comb begin
        state_s = state_r;
        if (ev_s[2]) begin
            case (state_r)
                MANUAL:    state_s = AUTO_UP;
                AUTO_UP:   state_s = AUTO_DOWN;
                AUTO_DOWN: state_s = PAUSE;
                PAUSE:     state_s = MANUAL;
                default:   state_s = MANUAL;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Next count; a mode press swallows any coincident step or tick.
    always_comb begin
        count_s = count_r;
        if (ev_s[2]) begin
            count_s = count_r;
        end else begin
            case (state_r)
                MANUAL, PAUSE: begin
                    if (up_step_s && !dn_step_s) begin
                        count_s = count_r + 4'd1;
                    end else if (dn_step_s && !up_step_s) begin
                        count_s = count_r - 4'd1;
                    end else begin
                        count_s = count_r;
                    end
                end
                AUTO_UP: begin
                    if (tick_s) begin
                        count_s = count_r + 4'd1;
                    end else begin
                        count_s = count_r;
                    end
                end
                AUTO_DOWN: begin
                    if (tick_s) begin
                        count_s = count_r - 4'd1;
                    end else begin
                        count_s = count_r;
                    end
                end
                default: count_s = count_r;
            endcase
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_r <= 4'd0;
        end else begin
            count_r <= count_s;
        end
    end

    // Prescaler: restarts on every state change so the first tick is a full period in.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc_r <= '0;
        end else if (state_s != state_r) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else if (auto_s) begin
            presc_r <= presc_r + 1'b1;
        end else begin
            presc_r <= '0;
        end
    end

    assign led_n_o = ~count_r;
    assign mode_o  = state_r;

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Directed bench for btn_led_ctrl with DEBOUNCE_CYCLES=4, TICK_CYCLES=8.

module tb_btn_led_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       btn_up_n_i = 1'b1;
    logic       btn_down_n_i = 1'b1;
    logic       btn_mode_n_i = 1'b1;
    logic [3:0] led_n_o;
    logic [1:0] mode_o;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [2:0] btn;   // {mode, down, up}
        logic [3:0] led;
        logic [1:0] mode;
    } vec_t;

    vec_t tbl[11];

`ifdef BTN_LED_CTRL_REPEAT_EN
    btn_led_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(8), .REPEAT_DELAY(16), .REPEAT_PERIOD(8)) dut (
`else
    btn_led_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(8)) dut (
`endif
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .btn_up_n_i(btn_up_n_i),
        .btn_down_n_i(btn_down_n_i),
        .btn_mode_n_i(btn_mode_n_i),
        .led_n_o(led_n_o),
        .mode_o(mode_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] el, input logic [1:0] em);
        n_vec++;
        if (led_n_o !== el || mode_o !== em) begin
            n_miss++;
            $display("FAIL %s: got led_n_o=%h mode_o=%b, expected led_n_o=%h mode_o=%b",
                     name, led_n_o, mode_o, el, em);
        end
    endtask

    task automatic set_btn(input logic [2:0] m);
        btn_up_n_i   = ~m[0];
        btn_down_n_i = ~m[1];
        btn_mode_n_i = ~m[2];
    endtask

    task automatic press(input logic [2:0] m);
        set_btn(m);
        step(20);
        set_btn(3'b000);
        step(12);
    endtask

    initial begin
        logic [3:0] prev_led;
        logic [1:0] prev_mode;

        tbl[0]  = '{3'b001, 4'hE, 2'b00};
        tbl[1]  = '{3'b001, 4'hD, 2'b00};
        tbl[2]  = '{3'b001, 4'hC, 2'b00};
        tbl[3]  = '{3'b010, 4'hD, 2'b00};
        tbl[4]  = '{3'b010, 4'hE, 2'b00};
        tbl[5]  = '{3'b010, 4'hF, 2'b00};
        tbl[6]  = '{3'b010, 4'h0, 2'b00};
        tbl[7]  = '{3'b011, 4'h0, 2'b00};
        tbl[8]  = '{3'b001, 4'hF, 2'b00};
        tbl[9]  = '{3'b010, 4'h0, 2'b00};
        tbl[10] = '{3'b001, 4'hF, 2'b00};

        #1;
        check("reset_state", 4'hF, 2'b00);
        step(2);
        rst_n_i = 1'b1;
        step(2);
        check("after_reset", 4'hF, 2'b00);

        // Manual stepping: unchanged after 6 edges, updated on the 7th.
        prev_led  = 4'hF;
        prev_mode = 2'b00;
        for (int i = 0; i < 11; i++) begin
            set_btn(tbl[i].btn);
            step(6);
            check($sformatf("vec%0d_pre", i), prev_led, prev_mode);
            step(1);
            check($sformatf("vec%0d_post", i), tbl[i].led, tbl[i].mode);
            step(13);
            set_btn(3'b000);
            step(12);
            prev_led  = tbl[i].led;
            prev_mode = tbl[i].mode;
        end

        // Bounce then stable press: exactly one increment (0 -> 1).
        for (int i = 0; i < 15; i++) begin
            btn_up_n_i = ~btn_up_n_i;
            step(2);
        end
        btn_up_n_i = 1'b0;
        step(20);
        btn_up_n_i = 1'b1;
        step(12);
        check("bounce_one_step", 4'hE, 2'b00);

        // 3-cycle glitch: ignored.
        btn_up_n_i = 1'b0;
        step(3);
        btn_up_n_i = 1'b1;
        step(15);
        check("glitch_ignored", 4'hE, 2'b00);

        // Reach count 9, then reset asynchronously with up held through it.
        for (int i = 0; i < 8; i++) press(3'b001);
        check("count_nine", 4'h6, 2'b00);
        btn_up_n_i = 1'b0;
        step(2);
        #2 rst_n_i = 1'b0;
        #1 check("reset_async", 4'hF, 2'b00);
        step(3);
        rst_n_i = 1'b1;
        step(6);
        check("held_reset_pre", 4'hF, 2'b00);
        step(1);
        check("held_reset_press", 4'hE, 2'b00);
        btn_up_n_i = 1'b1;
        step(12);

        // Auto modes from count 1; edges counted from the first mode press.
        btn_mode_n_i = 1'b0;
        step(12);  btn_mode_n_i = 1'b1;                  // edge 12
        step(2);   check("auto_up_pre_tick", 4'hE, 2'b01); // edge 14
        step(1);   check("auto_up_tick1", 4'hD, 2'b01);    // edge 15
        step(8);   check("auto_up_tick2", 4'hC, 2'b01);    // edge 23
        step(8);   check("auto_up_tick3", 4'hB, 2'b01);    // edge 31
        step(1);   btn_mode_n_i = 1'b0;                    // edge 32
        step(7);   check("tick_vs_mode", 4'hB, 2'b10);     // edge 39
        step(5);   btn_mode_n_i = 1'b1;                    // edge 44
        step(2);   check("auto_dn_pre_tick", 4'hB, 2'b10); // edge 46
        step(1);   check("auto_dn_tick1", 4'hC, 2'b10);    // edge 47
        step(8);   check("auto_dn_tick2", 4'hD, 2'b10);    // edge 55
        step(1);   btn_mode_n_i = 1'b0;                    // edge 56
        step(7);   check("enter_pause", 4'hD, 2'b11);      // edge 63
        step(5);   btn_mode_n_i = 1'b1;                    // edge 68
        step(95);  check("pause_frozen", 4'hD, 2'b11);     // edge 163

        press(3'b001);
        check("pause_up_step", 4'hC, 2'b11);
        press(3'b010);
        check("pause_down_step", 4'hD, 2'b11);
        press(3'b001);
        check("pause_up_again", 4'hC, 2'b11);
        press(3'b101);
        check("mode_beats_up", 4'hC, 2'b00);

        // Held up button from count 3.
        btn_up_n_i = 1'b0;
        step(7);   check("hold_first_step", 4'hB, 2'b00);   // edge 7
`ifdef BTN_LED_CTRL_REPEAT_EN
        step(15);  check("repeat_pre", 4'hB, 2'b00);        // edge 22
        step(1);   check("repeat_first", 4'hA, 2'b00);      // edge 23
        step(33);  check("repeat_held", 4'h6, 2'b00);       // edge 56
        btn_up_n_i = 1'b1;
        step(20);  check("repeat_released", 4'h6, 2'b00);
`else
        step(49);  check("no_repeat_held", 4'hB, 2'b00);    // edge 56
        btn_up_n_i = 1'b1;
        step(20);  check("no_repeat_released", 4'hB, 2'b00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
